// File: rtl/sipo_pkg.sv
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared types and helpers for the SIPO deserializer.
//                Build option: SIPO_PARITY_EN appends an even-parity bit
//                to every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

  // Receiver state: waiting for a frame start, or mid-word
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } sipo_state_t;

  // Number of serial bits that make up one frame on the wire
  function automatic int frame_bits(input int width);
`ifdef SIPO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// ============================================================================
//  Module      : sipo_shift_reg
//  Description : Left-shift register for the serial receiver. New bits
//                enter at bit 0; load_first restarts the register with the
//                incoming bit as the only valid bit (frame resync).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            shift,
  input  logic            load_first,
  input  logic            serial_in,
  output logic [BITS-1:0] q
);

  // Shift in one bit per strobe; a frame start discards any partial word
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load_first) begin
      q <= {{(BITS-1){1'b0}}, serial_in};
    end else if (shift) begin
      q <= {q[BITS-2:0], serial_in};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Serial-in parallel-out receiver, MSB first. Assembles a
//                WIDTH-bit word per frame and presents it on a registered
//                valid/ready port with a sticky overrun flag.
//                Build option: SIPO_PARITY_EN adds a trailing even-parity
//                bit per frame and reports it on parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             frame,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int              FRAME_BITS = frame_bits(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BITS - 1);

  sipo_state_t           state;
  logic [CNT_W-1:0]      count;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] assembled;
  logic [WIDTH-1:0]      word;
  logic                  start;
  logic                  advance;
  logic                  complete;
  logic                  load;
  logic                  drop;

  // A frame strobe always (re)starts a word; plain strobes only count mid-word
  assign start    = shift_en && frame;
  assign advance  = shift_en && !frame && (state == RECV);
  assign complete = advance && (count == LAST_CNT);

  // A finished word is taken unless an unconsumed word is still held
  assign load = complete && (!out_valid || out_ready);
  assign drop = complete && out_valid && !out_ready;

  // The completing bit is folded in here rather than waiting for the register
  assign assembled = {sr[FRAME_BITS-2:0], serial_in};

`ifdef SIPO_PARITY_EN
  assign word = assembled[FRAME_BITS-1:1];
`else
  assign word = assembled;
`endif

  assign busy = (state == RECV);

  sipo_shift_reg #(
    .BITS (FRAME_BITS)
  ) u_shift_reg (
    .clock      (clock),
    .reset      (reset),
    .shift      (advance),
    .load_first (start),
    .serial_in  (serial_in),
    .q          (sr)
  );

  // Frame state machine and bit counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RECV;
            count <= CNT_W'(1);
          end
        end
        RECV: begin
          if (start) begin
            count <= CNT_W'(1);
          end else if (complete) begin
            state <= IDLE;
            count <= '0;
          end else if (advance) begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Output word register, handshake and sticky overrun (set beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        data_out  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity status travels with the word under the same load/drop rules
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= ^assembled;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// ============================================================================
//  Module      : tb_sipo_deserializer
//  Description : Scoreboard bench for sipo_deserializer. A bit-list model
//                predicts delivered words; a negedge monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_deserializer;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             serial_in;
  logic             shift_en;
  logic             frame;
  logic             out_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .shift_en    (shift_en),
    .frame       (frame),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clock = ~clock;

  // Reference model state
  int               rx_bits[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_data;
  logic             exp_valid;
  logic             exp_ovr;
  logic             exp_perr;
  bit               mon_en = 0;
  int               n_checks = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of the edge just taken, using the inputs that were live
  task automatic model_update();
    bit done;
    int w;
    int ones;
    done = 0;
    if (reset) begin
      rx_bits.delete();
      sb_q.delete();
      exp_data  = '0;
      exp_valid = 0;
      exp_ovr   = 0;
      exp_perr  = 0;
      return;
    end
    if (overrun_clr) exp_ovr = 0;
    if (shift_en) begin
      if (frame) begin
        rx_bits.delete();
        rx_bits.push_back(int'(serial_in));
      end else if (rx_bits.size() > 0) begin
        rx_bits.push_back(int'(serial_in));
      end
    end
    if (rx_bits.size() == FB) done = 1;
    if (done) begin
      w = 0;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) w = w * 2 + rx_bits[i];
      for (int i = 0; i < FB; i++) ones += rx_bits[i];
      rx_bits.delete();
      if (!exp_valid || out_ready) begin
        exp_data  = WIDTH'(w);
        exp_valid = 1;
        exp_perr  = (FB > WIDTH) ? logic'(ones % 2) : 1'b0;
        sb_q.push_back(WIDTH'(w));
      end else begin
        exp_ovr = 1;
      end
    end else if (exp_valid && out_ready) begin
      exp_valid = 0;
    end
  endtask

  task automatic step(input logic f, input logic s, input logic se,
                      input logic rdy, input logic clr, input logic rst);
    frame       = f;
    serial_in   = s;
    shift_en    = se;
    out_ready   = rdy;
    overrun_clr = clr;
    reset       = rst;
    @(posedge clock);
    #1;
    model_update();
  endtask

  // One complete frame; parity bit (if any) is even parity, inverted when bad
  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_body,
                           input logic rdy_last, input logic bad);
    logic b;
    for (int i = 0; i < FB; i++) begin
      b = (i < WIDTH) ? w[WIDTH-1-i] : ((^w) ^ bad);
      step(i == 0, b, 1'b1, (i == FB - 1) ? rdy_last : rdy_body, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compare outputs against the model and retire accepted words
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("out_valid", out_valid, exp_valid);
        check("data_out", data_out, exp_data);
        check("overrun", overrun, exp_ovr);
        check("busy", busy, rx_bits.size() > 0);
        check("parity_err", parity_err, exp_perr);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard: word %0h delivered, none expected", data_out);
          end else begin
            check("delivered_word", data_out, sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    mon_en = 1;
    check("rst_data", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_perr", parity_err, 0);

    // Basic word, consumer always ready
    step(1, 1, 1, 1, 0, 0);
    check("t1_busy_mid", busy, 1);
    check("t1_valid_mid", out_valid, 0);
    for (int i = 1; i < FB; i++) begin
      step(0, (i < WIDTH) ? ((4'b1011 >> (WIDTH - 1 - i)) & 1) : 1'b1, 1, 1, 0, 0);
    end
    check("t1_valid", out_valid, 1);
    check("t1_data", data_out, 4'b1011);
    check("t1_busy_end", busy, 0);
    step(0, 0, 0, 1, 0, 0);

    // Resync after a two-bit partial word
    step(1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    send_word(4'b0110, 1, 1, 0);
    check("t2_data", data_out, 4'b0110);
    check("t2_overrun", overrun, 0);
    step(0, 0, 0, 1, 0, 0);

    // Overrun, clear, then drain
    send_word(4'b1001, 0, 0, 0);
    send_word(4'b0110, 0, 0, 0);
    check("t3_data", data_out, 4'b1001);
    check("t3_overrun", overrun, 1);
    step(0, 0, 0, 0, 1, 0);
    check("t3_ovr_clr", overrun, 0);
    step(0, 0, 0, 1, 0, 0);
    check("t3_drain", out_valid, 0);

    // Completion coincides with handshake
    send_word(4'b0011, 0, 0, 0);
    send_word(4'b1100, 0, 1, 0);
    check("t4_data", data_out, 4'b1100);
    check("t4_valid", out_valid, 1);
    check("t4_overrun", overrun, 0);
    step(0, 0, 0, 1, 0, 0);

    // Reset in mid-word
    send_word(4'b0101, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("t5_busy_pre", busy, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t5_data", data_out, 0);
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    step(0, 1, 1, 1, 0, 0);
    check("t5_ignored", busy, 0);

`ifdef SIPO_PARITY_EN
    send_word(4'b1011, 1, 1, 0);
    check("t6_perr_ok", parity_err, 0);
    check("t6_data_ok", data_out, 4'b1011);
    send_word(4'b1011, 1, 1, 1);
    check("t6_perr_bad", parity_err, 1);
    check("t6_valid_bad", out_valid, 1);
    step(0, 0, 0, 1, 0, 0);
`endif

    // Randomized traffic mixing clean frames with arbitrary strobes
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_word(WIDTH'($urandom), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < 3; k++) begin
          step(logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 9) < 7),
               logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 99) == 0));
        end
      end
    end

    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
